// File: rtl/brent_kung_sub_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : brent_kung_sub_pipe
//  Description : 4-bit subtractor, diff = (a - b - bin) mod 16, bout = borrow.
//                The borrow is resolved with a Brent-Kung prefix tree that is
//                split across a 3-stage valid/ready pipeline:
//                  S1 - per-bit generate/propagate/half-difference
//                  S2 - pairwise group terms and the 4-bit group term
//                  S3 - borrow resolution and final difference
//                Each stage holds its contents when the next stage cannot
//                accept, so back-pressure ripples combinationally from
//                out_ready to in_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module brent_kung_sub_pipe (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] diff,
    output logic       bout
);

    localparam int c_width = 4;

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    // S1: per-bit terms
    logic               s1_valid_q, s1_valid_d;
    logic [c_width-1:0] s1_g_q,     s1_g_d;
    logic [c_width-1:0] s1_p_q,     s1_p_d;
    logic [c_width-1:0] s1_h_q,     s1_h_d;
    logic               s1_bin_q,   s1_bin_d;

    // S2: group terms plus forwarded per-bit terms. Only the even-position
    // generate/propagate bits are still needed downstream: the odd
    // positions are fully summarised by the (P10,G10) and (P32,G32) groups.
    logic               s2_valid_q, s2_valid_d;
    logic [1:0]         s2_g_q,     s2_g_d;     // {g2, g0}
    logic [1:0]         s2_p_q,     s2_p_d;     // {p2, p0}
    logic [c_width-1:0] s2_h_q,     s2_h_d;
    logic               s2_bin_q,   s2_bin_d;
    logic               s2_g10_q,   s2_g10_d;
    logic               s2_p10_q,   s2_p10_d;
    logic               s2_g32_q,   s2_g32_d;
    logic               s2_p32_q,   s2_p32_d;
    logic               s2_g30_q,   s2_g30_d;
    logic               s2_p30_q,   s2_p30_d;

    // S3: final result, drives the outputs directly
    logic               s3_valid_q, s3_valid_d;
    logic [c_width-1:0] s3_diff_q,  s3_diff_d;
    logic               s3_bout_q,  s3_bout_d;

    // ------------------------------------------------------------------
    // Handshake / stall chain
    // ------------------------------------------------------------------
    logic w_s3_free;    // S3 can take new data this cycle
    logic w_s2_adv;     // S2 moves into S3 this cycle
    logic w_s2_free;    // S2 can take new data this cycle
    logic w_s1_adv;     // S1 moves into S2 this cycle
    logic w_in_fire;    // operand set accepted into S1 this cycle

    // Combinational datapath wires
    logic               w_g10, w_p10, w_g32, w_p32, w_g30, w_p30;
    logic               w_c1, w_c2, w_c3, w_c4;
    logic [c_width-1:0] w_borrow;

    // Stall chain: a stage is free when empty or draining on this same edge
    always_comb begin
        w_s3_free = !s3_valid_q || out_ready;
        w_s2_adv  = s2_valid_q && w_s3_free;
        w_s2_free = !s2_valid_q || w_s2_adv;
        w_s1_adv  = s1_valid_q && w_s2_free;
        in_ready  = !s1_valid_q || w_s1_adv;
        w_in_fire = in_valid && in_ready;
    end

    // ------------------------------------------------------------------
    // Stage 1: load per-bit borrow generate / propagate / half-difference
    // ------------------------------------------------------------------
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_g_d     = s1_g_q;
        s1_p_d     = s1_p_q;
        s1_h_d     = s1_h_q;
        s1_bin_d   = s1_bin_q;
        if (w_in_fire) begin
            s1_valid_d = 1'b1;
            s1_g_d     = ~a & b;
            s1_p_d     = ~(a ^ b);
            s1_h_d     = a ^ b;
            s1_bin_d   = bin;
        end else if (w_s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: Brent-Kung up-sweep - pairwise groups, then the 4-bit group
    // ------------------------------------------------------------------
    always_comb begin
        w_g10 = s1_g_q[1] | (s1_p_q[1] & s1_g_q[0]);
        w_p10 = s1_p_q[1] & s1_p_q[0];
        w_g32 = s1_g_q[3] | (s1_p_q[3] & s1_g_q[2]);
        w_p32 = s1_p_q[3] & s1_p_q[2];
        w_g30 = w_g32 | (w_p32 & w_g10);
        w_p30 = w_p32 & w_p10;
    end

    // Stage 2 register load: new data when S1 advances, else hold
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_g_d     = s2_g_q;
        s2_p_d     = s2_p_q;
        s2_h_d     = s2_h_q;
        s2_bin_d   = s2_bin_q;
        s2_g10_d   = s2_g10_q;
        s2_p10_d   = s2_p10_q;
        s2_g32_d   = s2_g32_q;
        s2_p32_d   = s2_p32_q;
        s2_g30_d   = s2_g30_q;
        s2_p30_d   = s2_p30_q;
        if (w_s1_adv) begin
            s2_valid_d = 1'b1;
            s2_g_d     = {s1_g_q[2], s1_g_q[0]};
            s2_p_d     = {s1_p_q[2], s1_p_q[0]};
            s2_h_d     = s1_h_q;
            s2_bin_d   = s1_bin_q;
            s2_g10_d   = w_g10;
            s2_p10_d   = w_p10;
            s2_g32_d   = w_g32;
            s2_p32_d   = w_p32;
            s2_g30_d   = w_g30;
            s2_p30_d   = w_p30;
        end else if (w_s2_adv) begin
            s2_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: down-sweep - resolve every borrow from borrow-in
    // ------------------------------------------------------------------
    always_comb begin
        w_c1     = s2_g_q[0] | (s2_p_q[0] & s2_bin_q);
        w_c2     = s2_g10_q  | (s2_p10_q  & s2_bin_q);
        w_c3     = s2_g_q[1] | (s2_p_q[1] & w_c2);
        w_c4     = s2_g30_q  | (s2_p30_q  & s2_bin_q);
        w_borrow = {w_c3, w_c2, w_c1, s2_bin_q};
    end

    // Stage 3 register load: result is held while downstream stalls
    always_comb begin
        s3_valid_d = s3_valid_q;
        s3_diff_d  = s3_diff_q;
        s3_bout_d  = s3_bout_q;
        if (w_s2_adv) begin
            s3_valid_d = 1'b1;
            s3_diff_d  = s2_h_q ^ w_borrow;
            s3_bout_d  = w_c4;
        end else if (s3_valid_q && out_ready) begin
            s3_valid_d = 1'b0;
        end
    end

    // All pipeline state, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_g_q     <= '0;
            s1_p_q     <= '0;
            s1_h_q     <= '0;
            s1_bin_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_g_q     <= '0;
            s2_p_q     <= '0;
            s2_h_q     <= '0;
            s2_bin_q   <= 1'b0;
            s2_g10_q   <= 1'b0;
            s2_p10_q   <= 1'b0;
            s2_g32_q   <= 1'b0;
            s2_p32_q   <= 1'b0;
            s2_g30_q   <= 1'b0;
            s2_p30_q   <= 1'b0;
            s3_valid_q <= 1'b0;
            s3_diff_q  <= '0;
            s3_bout_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_g_q     <= s1_g_d;
            s1_p_q     <= s1_p_d;
            s1_h_q     <= s1_h_d;
            s1_bin_q   <= s1_bin_d;
            s2_valid_q <= s2_valid_d;
            s2_g_q     <= s2_g_d;
            s2_p_q     <= s2_p_d;
            s2_h_q     <= s2_h_d;
            s2_bin_q   <= s2_bin_d;
            s2_g10_q   <= s2_g10_d;
            s2_p10_q   <= s2_p10_d;
            s2_g32_q   <= s2_g32_d;
            s2_p32_q   <= s2_p32_d;
            s2_g30_q   <= s2_g30_d;
            s2_p30_q   <= s2_p30_d;
            s3_valid_q <= s3_valid_d;
            s3_diff_q  <= s3_diff_d;
            s3_bout_q  <= s3_bout_d;
        end
    end

    assign out_valid = s3_valid_q;
    assign diff      = s3_diff_q;
    assign bout      = s3_bout_q;

endmodule
`default_nettype wire

// File: tb/tb_brent_kung_sub_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_brent_kung_sub_pipe
//  Description : Directed and exhaustive self-checking bench for
//                brent_kung_sub_pipe. Inputs change and outputs are sampled
//                around the falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_brent_kung_sub_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] a = 4'd0;
    logic [3:0] b = 4'd0;
    logic       bin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] diff;
    logic       bout;

    int n_cmp  = 0;
    int n_fail = 0;

    brent_kung_sub_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
    );

    always #5 clk = ~clk;

    // One full clock: through the rising edge, then to the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({out_valid, diff, bout} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b diff=%0d bout=%b, need 0/0/0", out_valid, diff, bout);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, need 1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [3:0] va [4];
        logic [3:0] vb [4];
        logic       vc [4];
        logic [3:0] ed [4];
        logic       eb [4];
        va = '{4'd5,  4'd3,  4'd0,  4'd15};
        vb = '{4'd3,  4'd5,  4'd0,  4'd15};
        vc = '{1'b0,  1'b0,  1'b1,  1'b1};
        ed = '{4'd2,  4'd14, 4'd15, 4'd15};
        eb = '{1'b0,  1'b1,  1'b1,  1'b1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            a = va[i]; b = vb[i]; bin = vc[i];
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_in_ready[%0d]: got %b, need 1", i, in_ready);
            end
            tick();
            in_valid = 1'b0;
            a = 4'd0; b = 4'd0; bin = 1'b0;
            tick();
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_early[%0d]: out_valid=%b after 2 edges, need 0", i, out_valid);
            end
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || diff !== ed[i] || bout !== eb[i]) begin
                n_fail++;
                $display("FAIL basic_result[%0d]: got valid=%b diff=%0d bout=%b, need 1/%0d/%b",
                         i, out_valid, diff, bout, ed[i], eb[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] va [3];
        logic [3:0] vb [3];
        logic [3:0] ed [3];
        logic       eb [3];
        va = '{4'd9, 4'd4,  4'd8};
        vb = '{4'd4, 4'd9,  4'd8};
        ed = '{4'd5, 4'd11, 4'd0};
        eb = '{1'b0, 1'b1,  1'b0};
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = va[i]; b = vb[i]; bin = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || diff !== ed[i] || bout !== eb[i]) begin
                n_fail++;
                $display("FAIL b2b_result[%0d]: got valid=%b diff=%0d bout=%b, need 1/%0d/%b",
                         i, out_valid, diff, bout, ed[i], eb[i]);
            end
            tick();
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drained: out_valid=%b, need 0", out_valid);
        end
    endtask

    task automatic test_stall();
        logic [3:0] va [3];
        logic [3:0] vb [3];
        logic       vc [3];
        logic [3:0] ed [3];
        logic       eb [3];
        va = '{4'd7, 4'd2,  4'd10};
        vb = '{4'd2, 4'd7,  4'd3};
        vc = '{1'b1, 1'b0,  1'b1};
        ed = '{4'd4, 4'd11, 4'd6};
        eb = '{1'b0, 1'b1,  1'b0};
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = va[i]; b = vb[i]; bin = vc[i];
            tick();
        end
        // Offer a fourth operand set that must not be taken while full
        a = 4'd1; b = 4'd1; bin = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_full_ready: in_ready=%b, need 0", in_ready);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || diff !== ed[0] || bout !== eb[0] || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got valid=%b diff=%0d bout=%b rdy=%b, need 1/%0d/%b/0",
                         k, out_valid, diff, bout, in_ready, ed[0], eb[0]);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release_ready: in_ready=%b, need 1", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || diff !== ed[i] || bout !== eb[i]) begin
                n_fail++;
                $display("FAIL stall_drain[%0d]: got valid=%b diff=%0d bout=%b, need 1/%0d/%b",
                         i, out_valid, diff, bout, ed[i], eb[i]);
            end
            tick();
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_no_extra: out_valid=%b, need 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = 4'd12; b = 4'd3; bin = 1'b0;
        tick();
        a = 4'd6;  b = 4'd1; bin = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || diff !== 4'd9) begin
            n_fail++;
            $display("FAIL rstmid_pre: got valid=%b diff=%0d, need 1/9", out_valid, diff);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || diff !== 4'd0 || bout !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: got valid=%b diff=%0d bout=%b, need 0/0/0", out_valid, diff, bout);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_ready: in_ready=%b, need 1", in_ready);
        end
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_ghost: stale result seen=%b, need 0", seen);
        end
        in_valid = 1'b1;
        a = 4'd1; b = 4'd2; bin = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || diff !== 4'd15 || bout !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_after: got valid=%b diff=%0d bout=%b, need 1/15/1", out_valid, diff, bout);
        end
        tick();
    endtask

    task automatic test_exhaustive();
        logic [8:0] exp_q [$];
        logic [8:0] e;
        logic [3:0] ed;
        logic       eb;
        int         sent = 0;
        int         got = 0;
        int         cyc = 0;
        while (got < 512 && cyc < 20000) begin
            @(negedge clk);
            in_valid  = (sent < 512) && ($urandom_range(0, 3) != 0);
            {a, b, bin} = sent[8:0];
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL exh_spurious: result diff=%0d bout=%b with nothing pending", diff, bout);
                end else begin
                    e  = exp_q.pop_front();
                    ed = 4'(e[8:5] - e[4:1] - {3'b000, e[0]});
                    eb = ({1'b0, e[8:5]} < ({1'b0, e[4:1]} + {4'b0000, e[0]}));
                    if (diff !== ed || bout !== eb) begin
                        n_fail++;
                        $display("FAIL exh_result a=%0d b=%0d bin=%b: got diff=%0d bout=%b, need %0d/%b",
                                 e[8:5], e[4:1], e[0], diff, bout, ed, eb);
                    end
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(sent[8:0]);
                sent++;
            end
            cyc++;
        end
        n_cmp++;
        if (got != 512) begin
            n_fail++;
            $display("FAIL exh_timeout: got %0d results, need 512", got);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_exhaustive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/brent_kung_sub_pipe.md
BRENT_KUNG_SUB_PIPE -- requirements
Module: brent_kung_sub_pipe

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low (ports clk, rst_n).
REQ-002 The block SHALL have no parameters; operand width is fixed at 4 bits.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  upstream offers an operand set this cycle.
REQ-006 in_ready  output  1  block accepts the operand set this cycle.
REQ-007 a  input  4  minuend.
REQ-008 b  input  4  subtrahend.
REQ-009 bin  input  1  borrow-in.
REQ-010 out_valid  output  1  diff/bout hold a valid result.
REQ-011 out_ready  input  1  downstream consumes the result this cycle.
REQ-012 diff  output  4  (a - b - bin) mod 16.
REQ-013 bout  output  1  borrow-out: 1 when a < b + bin (unsigned).

Function
REQ-014 An input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; an output transfer SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-015 The datapath SHALL be a 3-stage register pipeline, S1 -> S2 -> S3, each stage with its own valid bit; S3 registers drive out_valid/diff/bout directly.
REQ-016 S1 SHALL capture per-bit borrow-generate g_i = ~a_i & b_i, borrow-propagate p_i = ~(a_i ^ b_i), half-difference h_i = a_i ^ b_i, and bin.
REQ-017 S2 SHALL capture the group terms (P10,G10) and (P32,G32) with G_hi:lo = g_hi | (p_hi & g_lo) and P_hi:lo = p_hi & p_lo, plus P30,G30 formed from them; it SHALL also carry h, p, g and bin forward.
REQ-018 S3 SHALL resolve borrows c0=bin, c1=g0|p0&c0, c2=G10|P10&c0, c3=g2|p2&c2, c4=G30|P30&c0; it SHALL register diff_i = h_i ^ c_i and bout = c4.
REQ-019 Latency SHALL be exactly 3 cycles from input transfer to out_valid=1 when out_ready stays 1.
REQ-020 Throughput SHALL be one transfer per cycle with no bubbles while out_ready=1.
REQ-021 A stage SHALL advance when it is valid and the next stage is empty or transferring in the same cycle; otherwise it SHALL hold its contents.
REQ-022 in_ready SHALL equal (!S1.valid) | S1 advances this cycle; in_ready SHALL be combinational from out_ready through the stall chain.
REQ-023 While out_valid=1 and out_ready=0, diff and bout SHALL remain stable until the transfer.
REQ-024 With all three stages full and out_ready=0, in_ready SHALL be 0 and no operand set SHALL be dropped or duplicated.
REQ-025 A stage that is emptied and refilled on the same edge SHALL take the new data; an empty stage SHALL not assert valid to the next stage.
REQ-026 in_valid with in_ready=0 SHALL have no effect; a, b and bin SHALL be sampled only on an input transfer.
REQ-027 Results SHALL emerge in acceptance order.

Reset
REQ-028 On rst_n=0, all valid bits and all datapath registers SHALL clear to 0 immediately, without waiting for clk: out_valid=0, diff=0, bout=0.
REQ-029 in_ready SHALL be 1 whenever rst_n=1 and S1 is empty, including the first cycle after reset release.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight results; none SHALL appear after release.

Verification
REQ-031 a=5, b=3, bin=0, out_ready=1 -> 3 cycles later out_valid=1, diff=2, bout=0.
REQ-032 a=3, b=5, bin=0 -> diff=14, bout=1; a=0, b=0, bin=1 -> diff=15, bout=1; a=15, b=15, bin=1 -> diff=15, bout=1.
REQ-033 Back-to-back inputs (9,4,0), (4,9,0), (8,8,0), out_ready=1 -> outputs on consecutive cycles 3,4,5: (5,0), (11,1), (0,0).
REQ-034 Three inputs accepted, then out_ready=0 for 4 cycles -> in_ready=0 once S1-S3 are full, the first result is held stable, and all three results emerge in order after out_ready=1.
REQ-035 rst_n pulsed low with two transactions in flight -> out_valid=0 and diff=0 at once; no result appears after release; the next input returns its result after 3 cycles.
REQ-036 Exhaustive random run over all 512 (a,b,bin) combinations with random in_valid/out_ready -> every result equals the reference (a-b-bin) mod 16 and borrow, in order.
